// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin owner of one shared SPI master core.
// A grant is held for a whole burst; bursts are separated by an idle gap.
module spi_xfer_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 16,
    parameter int GAP_CYC = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic               io_apb_PCLK,
    input  logic               io_apb_PRESET,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_data,
    output logic [NREQ-1:0]    rsp_err,
    output logic               spi_tx_valid,
    output logic [DW-1:0]      spi_tx_data,
    input  logic               spi_tx_ready,
    input  logic               spi_rx_valid,
    input  logic [DW-1:0]      spi_rx_data,
    output logic [NREQ-1:0]    cs_sel,
    output logic               busy
);
    localparam int PW = $clog2(NREQ);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam logic [TW-1:0] TO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_RX, GAP} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   grant_q, grant_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            last_q, last_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [NREQ-1:0] rsp_err_q, rsp_err_d;
    logic [DW-1:0]   rsp_data_q, rsp_data_d;
    logic [NREQ-1:0] grant_oh;
    logic [PW-1:0]   pick;
    logic            pick_ok;

    // First requesting index strictly after rr_ptr, wrapping around.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!pick_ok && req_valid[(int'(rr_ptr_q) + i) % NREQ]) begin
                pick    = PW'((int'(rr_ptr_q) + i) % NREQ);
                pick_ok = 1'b1;
            end
        end
    end

    assign grant_oh = NREQ'(1) << grant_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        rr_ptr_d     = rr_ptr_q;
        last_d       = last_q;
        to_cnt_d     = '0;
        gap_cnt_d    = '0;
        rsp_valid_d  = '0;
        rsp_err_d    = '0;
        rsp_data_d   = rsp_data_q;
        spi_tx_valid = 1'b0;
        spi_tx_data  = '0;
        req_ready    = '0;
        cs_sel       = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_ok) begin
                    grant_d = pick;
                    state_d = SEND;
                end
            end
            SEND: begin
                cs_sel       = grant_oh;
                spi_tx_valid = req_valid[grant_q];
                spi_tx_data  = req_data[grant_q*DW +: DW];
                req_ready    = grant_oh & {NREQ{spi_tx_ready}};
                if (spi_tx_valid && spi_tx_ready) begin
                    last_d  = req_last[grant_q];
                    state_d = WAIT_RX;
                end
            end
            WAIT_RX: begin
                cs_sel   = grant_oh;
                to_cnt_d = to_cnt_q + 1'b1;
                // A frame arriving on the final cycle still counts as success.
                if (spi_rx_valid) begin
                    rsp_valid_d = grant_oh;
                    rsp_data_d  = spi_rx_data;
                    state_d     = last_q ? GAP : SEND;
                end else if (TIMEOUT != 0 && to_cnt_q == TO_LAST) begin
                    rsp_err_d = grant_oh;
                    state_d   = GAP;
                end
            end
            GAP: begin
                rr_ptr_d  = grant_q;
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == GAP_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge io_apb_PCLK or posedge io_apb_PRESET) begin
        if (io_apb_PRESET) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= PW'(NREQ - 1);
            last_q      <= 1'b0;
            to_cnt_q    <= '0;
            gap_cnt_q   <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            last_q      <= last_d;
            to_cnt_q    <= to_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: scoreboard bench for spi_xfer_arbiter.
// Requester queues and a small SPI core model drive the DUT each negedge.
module tb_spi_xfer_arbiter;
    localparam int NREQ    = 4;
    localparam int DW      = 16;
    localparam int GAP_CYC = 4;
    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic        err;
        logic [1:0]  idx;
        logic [15:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    req_last = '0;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic [NREQ-1:0]    rsp_err;
    logic               spi_tx_valid;
    logic [DW-1:0]      spi_tx_data;
    logic               spi_tx_ready = 1'b0;
    logic               spi_rx_valid = 1'b0;
    logic [DW-1:0]      spi_rx_data = '0;
    logic [NREQ-1:0]    cs_sel;
    logic               busy;

    spi_xfer_arbiter #(
        .NREQ(NREQ), .DW(DW), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
    ) dut (
        .io_apb_PCLK  (clk),
        .io_apb_PRESET(rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .spi_tx_valid (spi_tx_valid),
        .spi_tx_data  (spi_tx_data),
        .spi_tx_ready (spi_tx_ready),
        .spi_rx_valid (spi_rx_valid),
        .spi_rx_data  (spi_rx_data),
        .cs_sel       (cs_sel),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    logic [16:0] rq[NREQ][$];
    logic [NREQ-1:0] req_en = '1;
    int          core_mode = 0;
    int          core_lat = 2;
    logic        gap_exact = 1'b0;
    int          cyc = 0;
    int          tx_cyc = 0;
    int          err_cyc = 0;
    int          rsp_cyc = 0;

    logic [NREQ-1:0] acc_req = '0;
    logic            acc_tx = 1'b0;
    logic [DW-1:0]   tx_cap = '0;
    logic            core_pend = 1'b0;
    int              core_cnt = 0;
    logic [DW-1:0]   core_data = '0;
    logic [NREQ-1:0] prev_cs = '0;
    int              idle_run = 0;
    logic            seen = 1'b0;
    logic            rxv;
    logic [DW-1:0]   rxd;
    exp_t            got;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // Requester and core model; also pops the scoreboard on responses.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rsp_valid != 0 || rsp_err != 0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexp", {24'd0, rsp_err, rsp_valid}, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk("rsp_valid", {28'd0, rsp_valid},
                        got.err ? 32'd0 : (32'd1 << got.idx));
                    chk("rsp_err", {28'd0, rsp_err},
                        got.err ? (32'd1 << got.idx) : 32'd0);
                    if (got.err) err_cyc = cyc;
                    else begin
                        chk("rsp_data", {16'd0, rsp_data}, {16'd0, got.data});
                        rsp_cyc = cyc;
                    end
                end
            end
            if (cs_sel != 0) begin
                if (prev_cs == 0) begin
                    chk("cs_onehot", {31'd0, $onehot(cs_sel)}, 32'd1);
                    if (seen) begin
                        if (gap_exact) chk("gap_len", idle_run, GAP_CYC + 1);
                        else chk("gap_min", {31'd0, idle_run >= GAP_CYC}, 32'd1);
                    end
                    seen = 1'b1;
                end else begin
                    chk("cs_hold", {28'd0, cs_sel}, {28'd0, prev_cs});
                end
                idle_run = 0;
            end else begin
                idle_run++;
            end
            prev_cs = cs_sel;

            for (int i = 0; i < NREQ; i++)
                if (acc_req[i]) void'(rq[i].pop_front());
            if (acc_tx) begin
                core_pend = 1'b1;
                core_cnt  = core_lat;
                core_data = tx_cap;
                tx_cyc    = cyc;
            end

            rxv = 1'b0;
            rxd = '0;
            if (core_mode == 2) begin
                rxv = 1'b1;
                rxd = 16'hDEAD;
            end else if (core_pend) begin
                if (core_cnt == 0) begin
                    core_pend = 1'b0;
                    if (core_mode == 0) begin
                        rxv = 1'b1;
                        rxd = ~core_data;
                    end
                end else begin
                    core_cnt--;
                end
            end
            spi_rx_valid = rxv;
            spi_rx_data  = rxd;
            spi_tx_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = req_en[i] && (rq[i].size() > 0);
                {req_last[i], req_data[i*DW +: DW]} =
                    (rq[i].size() > 0) ? rq[i][0] : 17'd0;
            end

            #1;
            acc_req = req_valid & req_ready;
            acc_tx  = spi_tx_valid && spi_tx_ready;
            tx_cap  = spi_tx_data;
            if (spi_tx_valid)
                chk("ready_cs", {28'd0, req_ready},
                    spi_tx_ready ? {28'd0, cs_sel} : 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input int r, input logic [15:0] d,
                        input logic last, input logic err);
        exp_t e;
        rq[r].push_back({last, d});
        e.err  = err;
        e.idx  = 2'(r);
        e.data = ~d;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        tick();
        while ((sb.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, sb.size() == 0 && !busy}, 32'd1);
    endtask

    task automatic wait_cs(input string tag, input logic [NREQ-1:0] v,
                           input int budget);
        int n = 0;
        while (cs_sel != v && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {28'd0, cs_sel}, {28'd0, v});
    endtask

    initial begin
        int n;
        // All four requesters pending out of reset; requester 0 has two bursts.
        push(0, 16'h1100, 1'b1, 1'b0);
        push(1, 16'h1101, 1'b1, 1'b0);
        push(2, 16'h1102, 1'b1, 1'b0);
        push(3, 16'h1103, 1'b1, 1'b0);
        push(0, 16'h1104, 1'b1, 1'b0);
        repeat (3) tick();
        chk("rst_cs", {28'd0, cs_sel}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_txv", {31'd0, spi_tx_valid}, 32'd0);
        chk("rst_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_rsp", {20'd0, rsp_err, rsp_valid, 4'd0}, 32'd0);
        chk("rst_data", {rsp_data, spi_tx_data}, 32'd0);
        gap_exact = 1'b1;
        rst = 1'b0;
        wait_cs("t2_first", 4'b0001, 5);
        wait_done("t2_done", 400);
        gap_exact = 1'b0;

        push(1, 16'h00A5, 1'b0, 1'b0);
        push(1, 16'h005A, 1'b1, 1'b0);
        wait_cs("t1_grant", 4'b0010, 20);
        wait_done("t1_done", 200);
        chk("t1_data", {16'd0, rsp_data}, 32'h0000FFA5);

        push(2, 16'h0301, 1'b0, 1'b0);
        push(2, 16'h0302, 1'b0, 1'b0);
        push(2, 16'h0303, 1'b1, 1'b0);
        wait_cs("t3_grant", 4'b0100, 20);
        push(0, 16'h0300, 1'b1, 1'b0);
        n = 0;
        while (sb.size() > 3 && n < 60) begin
            tick();
            n++;
        end
        chk("t3_first", sb.size(), 3);
        req_en[2] = 1'b0;
        repeat (10) begin
            tick();
            chk("t3_hold", {27'd0, cs_sel, req_ready[0]}, {27'd0, 4'b0100, 1'b0});
        end
        req_en[2] = 1'b1;
        wait_done("t3_done", 300);

        core_mode = 1;
        push(1, 16'h0401, 1'b1, 1'b1);
        wait_cs("t4_grant", 4'b0010, 20);
        push(3, 16'h0403, 1'b1, 1'b0);
        n = 0;
        while (sb.size() > 1 && n < 80) begin
            tick();
            n++;
        end
        core_mode = 0;
        chk("t4_err_left", sb.size(), 1);
        chk("t4_err_at", err_cyc - tx_cyc, TIMEOUT);
        wait_cs("t4_next", 4'b1000, 20);
        wait_done("t4_done", 200);

        core_mode = 2;
        repeat (3) tick();
        core_mode = 0;
        repeat (2) tick();
        chk("t6_idle_busy", {31'd0, busy}, 32'd0);
        chk("t6_hold", {16'd0, rsp_data}, 32'h0000FBFC);
        core_lat = 15;
        push(2, 16'h0602, 1'b1, 1'b0);
        wait_done("t6_coinc_done", 200);
        chk("t6_coinc_at", rsp_cyc - tx_cyc, TIMEOUT);
        core_lat = 2;

        core_mode = 1;
        rq[2].push_back({1'b1, 16'h0502});
        n = 0;
        while (!(busy && cs_sel == 4'b0100 && !spi_tx_valid) && n < 30) begin
            tick();
            n++;
        end
        chk("t5_in_wait", {31'd0, busy && cs_sel == 4'b0100 && !spi_tx_valid}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_async", {23'd0, cs_sel, busy, spi_tx_valid, req_ready}, 32'd0);
        repeat (3) tick();
        core_mode = 0;
        push(0, 16'h0500, 1'b1, 1'b0);
        push(3, 16'h0503, 1'b1, 1'b0);
        rst = 1'b0;
        wait_cs("t5_first", 4'b0001, 5);
        wait_done("t5_done", 200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
